// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM state encoding,
// grant identifiers and the tie-break rule used when both stages request.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_D  = 2'd2,
        ARB_RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

    // Alternate on a tie so neither stage can starve the other.
    function automatic gnt_t pick_grant(input logic if_req, input logic d_req, input gnt_t last_gnt);
        if (if_req && d_req) begin
            return (last_gnt == GNT_IF) ? GNT_D : GNT_IF;
        end
        return d_req ? GNT_D : GNT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the pipeline-side request/ack signals and the memory-side bus
// seen by the arbiter (slave) and by the pipeline/memory environment (master).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              stall_if;
    logic              stall_mem;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Counts cycles spent holding mem_en; done marks the cycle in which the
// fixed-latency memory presents valid read data.
module mem_wait_counter #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);
    localparam int               CNT_W = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LAT - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign done = enable && (cnt_reg == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between instruction fetch and
// the data stage: grant, hold the latched access for LAT cycles, then ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    arb_state_t        state_reg;
    gnt_t              last_gnt_reg;
    gnt_t              gnt_next;
    logic              mem_en_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              if_ack_reg;
    logic              d_ack_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              busy;
    logic              wait_done;

    assign gnt_next = pick_grant(bus.if_req, bus.d_req, last_gnt_reg);
    assign busy     = (state_reg == ARB_BUSY_IF) || (state_reg == ARB_BUSY_D);

    mem_wait_counter #(.LAT(LAT)) u_wait (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_reg == ARB_IDLE),
        .enable (busy),
        .done   (wait_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ARB_IDLE;
            last_gnt_reg <= GNT_IF;
            mem_en_reg   <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            if_ack_reg   <= 1'b0;
            d_ack_reg    <= 1'b0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        last_gnt_reg <= gnt_next;
                        mem_en_reg   <= 1'b1;
                        if (gnt_next == GNT_D) begin
                            state_reg <= ARB_BUSY_D;
                            we_reg    <= bus.d_we;
                            addr_reg  <= bus.d_addr;
                            wdata_reg <= bus.d_wdata;
                        end else begin
                            state_reg <= ARB_BUSY_IF;
                            we_reg    <= 1'b0;
                            addr_reg  <= bus.if_addr;
                        end
                    end
                end
                ARB_BUSY_IF, ARB_BUSY_D: begin
                    // Memory inputs come from the latched copy, so a requester
                    // misbehaving mid-access cannot disturb the cycle in flight.
                    if (wait_done) begin
                        state_reg  <= ARB_RESP;
                        mem_en_reg <= 1'b0;
                        we_reg     <= 1'b0;
                        if (state_reg == ARB_BUSY_IF) begin
                            if_ack_reg   <= 1'b1;
                            if_rdata_reg <= bus.mem_rdata;
                        end else begin
                            d_ack_reg <= 1'b1;
                            if (!we_reg) begin
                                d_rdata_reg <= bus.mem_rdata;
                            end
                        end
                    end
                end
                ARB_RESP: begin
                    if_ack_reg <= 1'b0;
                    d_ack_reg  <= 1'b0;
                    state_reg  <= ARB_IDLE;
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_we    = we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.if_ack    = if_ack_reg;
    assign bus.d_ack     = d_ack_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.stall_if  = bus.if_req & ~if_ack_reg;
    assign bus.stall_mem = bus.d_req & ~d_ack_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random bench for mem_port_arbiter; a transaction-level model
// predicts grant order, busy windows, acks and returned data per cycle.
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    function automatic logic [31:0] init_val(input logic [7:0] idx);
        if (idx == 8'h10) return 32'h2008_0001;
        return {8'hC3, idx, ~idx, 8'h5A};
    endfunction

    // Fixed-latency memory: data is valid only in the LAT-th cycle mem_en is held.
    int          held;
    logic [31:0] phys_mem [256];
    bit          phys_wr  [256];

    always @(posedge clk or posedge rst) begin
        if (rst) held <= 0;
        else     held <= bus.mem_en ? held + 1 : 0;
    end

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we && held == LAT - 1) begin
            phys_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            phys_wr[bus.mem_addr[9:2]]  <= 1'b1;
        end
    end

    always_comb begin
        bus.mem_rdata = 32'hBADC_0DE0;
        if (bus.mem_en && held == LAT - 1) begin
            bus.mem_rdata = phys_wr[bus.mem_addr[9:2]] ? phys_mem[bus.mem_addr[9:2]]
                                                        : init_val(bus.mem_addr[9:2]);
        end
    end

    assign bus1.mem_rdata = (bus1.mem_en && bus1.mem_addr == 32'h0000_0200) ? 32'h1234_5678 : 32'hBADC_0DE1;

    // Reference model state
    int          cyc;
    int          g_cyc, next_sample, owner, last_gnt, mode;
    bit          g_we;
    logic [31:0] g_rdata, exp_addr, exp_wdata, exp_if_rdata, exp_d_rdata;
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];
    bit          pend [2];
    bit          ack_now [2];
    bit          r_we [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%08h expected=%08h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        g_cyc = -1000; next_sample = 0; owner = 0; last_gnt = 0; g_we = 1'b0;
        g_rdata = '0; exp_addr = '0; exp_wdata = '0; exp_if_rdata = '0; exp_d_rdata = '0;
    endtask

    task automatic issue(input int s, input bit we, input logic [31:0] a, input logic [31:0] wd);
        pend[s] = 1'b1; r_we[s] = we; r_addr[s] = a; r_wdata[s] = wd;
    endtask

    task automatic new_req(input int s);
        issue(s, (s == 1) ? 1'($urandom_range(0, 1)) : 1'b0, 32'($urandom_range(0, 1023)), $urandom);
    endtask

    task automatic drive();
        bus.if_req  = pend[0];
        bus.if_addr = r_addr[0];
        bus.d_req   = pend[1];
        bus.d_we    = r_we[1];
        bus.d_addr  = r_addr[1];
        bus.d_wdata = r_wdata[1];
    endtask

    task automatic check_outputs();
        bit busy, ackc;
        busy = (cyc > g_cyc) && (cyc <= g_cyc + LAT);
        ackc = (cyc == g_cyc + LAT + 1);
        ack_now[0] = ackc && owner == 0;
        ack_now[1] = ackc && owner == 1;
        if (ackc && !g_we) begin
            if (owner == 1) exp_d_rdata = g_rdata;
            else            exp_if_rdata = g_rdata;
        end
        chk("mem_en",    32'(bus.mem_en), 32'(busy));
        chk("mem_we",    32'(bus.mem_we), 32'(busy && g_we));
        chk("mem_addr",  bus.mem_addr, exp_addr);
        chk("mem_wdata", bus.mem_wdata, exp_wdata);
        chk("if_ack",    32'(bus.if_ack), 32'(ack_now[0]));
        chk("d_ack",     32'(bus.d_ack), 32'(ack_now[1]));
        chk("if_rdata",  bus.if_rdata, exp_if_rdata);
        chk("d_rdata",   bus.d_rdata, exp_d_rdata);
    endtask

    task automatic update_requesters();
        for (int s = 0; s < 2; s++) begin
            if (ack_now[s]) pend[s] = 1'b0;
            if (!pend[s] && (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0))) new_req(s);
        end
    endtask

    // Decide what the arbiter grants at the edge closing the current cycle.
    task automatic model_grant();
        int         w;
        logic [7:0] idx;
        if (rst || cyc < next_sample || !(pend[0] || pend[1])) return;
        if (pend[0] && pend[1]) w = 1 - last_gnt;
        else                    w = pend[1] ? 1 : 0;
        owner = w; last_gnt = w; g_cyc = cyc; next_sample = cyc + LAT + 2;
        g_we = (w == 1) && r_we[1];
        exp_addr = r_addr[w];
        if (w == 1) exp_wdata = r_wdata[1];
        idx = r_addr[w][9:2];
        if (g_we) begin
            ref_mem[idx] = r_wdata[1];
            ref_wr[idx]  = 1'b1;
        end else begin
            g_rdata = ref_wr[idx] ? ref_mem[idx] : init_val(idx);
        end
    endtask

    task automatic tick_a();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
        update_requesters();
    endtask

    task automatic tick_b();
        drive();
        #1;
        chk("stall_if",  32'(bus.stall_if),  32'(pend[0] && !ack_now[0]));
        chk("stall_mem", 32'(bus.stall_mem), 32'(pend[1] && !ack_now[1]));
        model_grant();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick_a();
            tick_b();
        end
    endtask

    task automatic drain();
        mode = 0;
        for (int i = 0; i < 40 && (pend[0] || pend[1]); i++) run(1);
        chk("drain_if_pending", 32'(pend[0]), 32'd0);
        chk("drain_d_pending",  32'(pend[1]), 32'd0);
        run(LAT + 2);
    endtask

    initial begin
        rst = 1'b1;
        cyc = 0;
        mode = 0;
        for (int s = 0; s < 2; s++) begin
            pend[s] = 1'b0; ack_now[s] = 1'b0; r_we[s] = 1'b0; r_addr[s] = '0; r_wdata[s] = '0;
        end
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0;
        bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
        drive();
        model_reset();

        // Reset state, then release mid-cycle
        run(2);
        tick_a();
        rst = 1'b0;
        tick_b();
        run(2);

        // Lone fetch of 0x40
        tick_a(); issue(0, 1'b0, 32'h0000_0040, '0); tick_b();
        run(6);
        chk("fetch_0x40_rdata", bus.if_rdata, 32'h2008_0001);

        // Load abandoned by reset in its second busy cycle
        tick_a(); issue(1, 1'b0, 32'h0000_0080, '0); tick_b();
        run(1);
        @(posedge clk);
        cyc++;
        #1 chk("busy_before_rst", 32'(bus.mem_en), 32'd1);
        rst = 1'b1;
        #1 chk("rst_drops_mem_en", 32'(bus.mem_en), 32'd0);
        model_reset();
        @(negedge clk);
        check_outputs();
        update_requesters();
        tick_b();
        run(1);

        // Tie straight out of reset: D first, IF four cycles later
        tick_a();
        rst = 1'b0;
        issue(0, 1'b0, 32'h0000_0044, '0);
        tick_b();
        run(10);
        chk("tie_d_rdata",  bus.d_rdata,  init_val(8'h20));
        chk("tie_if_rdata", bus.if_rdata, init_val(8'h11));

        // Both stages hammering: grants must alternate
        mode = 1;
        run(24);
        drain();

        // Store then load back the same word
        tick_a(); issue(1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF); tick_b();
        run(6);
        tick_a(); issue(1, 1'b0, 32'h0000_0100, '0); tick_b();
        run(6);
        chk("store_readback", bus.d_rdata, 32'hDEAD_BEEF);

        // Fetch request withdrawn mid-access still completes
        tick_a(); issue(0, 1'b0, 32'h0000_0013, '0); tick_b();
        tick_a(); pend[0] = 1'b0; tick_b();
        run(5);

        // Randomized traffic
        mode = 2;
        run(400);
        drain();

        // LAT=1 instance: load 0x200
        @(negedge clk);
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h0000_0200;
        @(negedge clk);
        chk("lat1_mem_en_busy",  32'(bus1.mem_en), 32'd1);
        chk("lat1_d_ack_busy",   32'(bus1.d_ack), 32'd0);
        chk("lat1_stall_busy",   32'(bus1.stall_mem), 32'd1);
        @(negedge clk);
        chk("lat1_d_ack",        32'(bus1.d_ack), 32'd1);
        chk("lat1_d_rdata",      bus1.d_rdata, 32'h1234_5678);
        chk("lat1_mem_en_resp",  32'(bus1.mem_en), 32'd0);
        chk("lat1_stall_resp",   32'(bus1.stall_mem), 32'd0);
        bus1.d_req = 1'b0;
        @(negedge clk);
        chk("lat1_d_ack_after",  32'(bus1.d_ack), 32'd0);
        chk("lat1_rdata_hold",   bus1.d_rdata, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
